// File: rtl/flash_sample_sequencer_pkg.sv
// Shared types and defaults for the flash sample player.
// Word order helper keeps half selection identical wherever it is used.
package audio_pkg;

  localparam int ADDR_W = 23;
  localparam logic [ADDR_W-1:0] DEF_START_ADDR = 23'h0;
  localparam logic [ADDR_W-1:0] DEF_END_ADDR   = 23'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    HALF0,
    HALF1
  } state_t;

  // Forward plays lower then upper; reverse flips the order.
  function automatic logic [15:0] pick_half(input logic [31:0] word,
                                            input logic second,
                                            input logic rev);
    return (second ^ rev) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/flash_sample_sequencer_if.sv
// Avalon-MM read-only master bundle between the sequencer and flash.
// Single outstanding read; slave stalls with waitrequest, returns with readdatavalid.
interface flash_sample_sequencer_if #(
  parameter int ADDR_W = audio_pkg::ADDR_W
);

  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_waitrequest;
  logic              flash_readdatavalid;
  logic [31:0]       flash_readdata;

  modport master (
    output flash_read, flash_address,
    input  flash_waitrequest, flash_readdatavalid, flash_readdata
  );

  modport slave (
    input  flash_read, flash_address,
    output flash_waitrequest, flash_readdatavalid, flash_readdata
  );

endinterface

// File: rtl/flash_sample_sequencer_edge_detect.sv
// Rising-edge detector: rise is combinational from in and a one-cycle history register.
// No latency beyond the input; a level held high yields a single rise.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= in;
  end

  assign rise = in & ~q;

endmodule

// File: rtl/flash_sample_sequencer.sv
// Streams 16-bit samples out of 32-bit flash words, one per sample-tick rising edge.
// Tick to audio_valid is one cycle; slow flash is absorbed by a one-deep pending tick, beyond that overrun latches.
module flash_sample_sequencer #(
  parameter int                ADDR_W     = audio_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = audio_pkg::DEF_START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = audio_pkg::DEF_END_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     play,
  input  logic                     reverse,
  input  logic                     restart,
  flash_sample_sequencer_if.master flash,
  output logic [15:0]              audio_data,
  output logic                     audio_valid,
  output logic                     overrun
);

  import audio_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic              tick_rise;
  logic              pending;
  logic              restart_pending;
  logic              rst_req;
  logic [31:0]       word;
  logic              emit;
  logic              second;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] adv_addr;

  edge_detect u_tick_edge (
    .clk  (clk),
    .reset(reset),
    .in   (sample_tick),
    .rise (tick_rise)
  );

  assign rst_req    = restart | restart_pending;
  assign start_addr = reverse ? END_ADDR : START_ADDR;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (play) state_nxt = FETCH;
      FETCH:     if (!flash.flash_waitrequest) state_nxt = WAIT_DATA;
      WAIT_DATA: if (flash.flash_readdatavalid) state_nxt = rst_req ? FETCH : HALF0;
      HALF0: begin
        if (rst_req)   state_nxt = FETCH;
        else if (emit) state_nxt = HALF1;
      end
      HALF1:     if (rst_req || emit) state_nxt = FETCH;
      default:   state_nxt = IDLE;
    endcase
  end

  // A pended tick stands in for a live one when the word lands.
  always_comb begin
    emit     = 1'b0;
    second   = 1'b0;
    adv_addr = flash.flash_address;
    case (state)
      HALF0: emit = play & ~rst_req & (tick_rise | pending);
      HALF1: begin
        emit   = play & ~rst_req & (tick_rise | pending);
        second = 1'b1;
      end
      default: ;
    endcase
    if (reverse)
      adv_addr = (flash.flash_address == START_ADDR) ? END_ADDR : flash.flash_address - ADDR_ONE;
    else
      adv_addr = (flash.flash_address == END_ADDR) ? START_ADDR : flash.flash_address + ADDR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash.flash_read    <= 1'b0;
      flash.flash_address <= START_ADDR;
      audio_data          <= 16'h0;
      audio_valid         <= 1'b0;
      overrun             <= 1'b0;
      pending             <= 1'b0;
      restart_pending     <= 1'b0;
      word                <= 32'h0;
    end else begin
      flash.flash_read <= (state_nxt == FETCH);
      audio_valid      <= emit;
      if (emit) audio_data <= pick_half(word, second, reverse);

      case (state)
        IDLE: begin
          if (restart) flash.flash_address <= start_addr;
          pending         <= 1'b0;
          restart_pending <= 1'b0;
        end
        FETCH, WAIT_DATA: begin
          if (!play) begin
            pending <= 1'b0;
          end else if (tick_rise) begin
            if (pending) overrun <= 1'b1;
            pending <= 1'b1;
          end
          // The read in flight is never abandoned; a restart is honoured once it returns.
          if (state == WAIT_DATA && flash.flash_readdatavalid) begin
            if (rst_req) begin
              flash.flash_address <= start_addr;
              restart_pending     <= 1'b0;
            end else begin
              word <= flash.flash_readdata;
            end
          end else if (restart) begin
            restart_pending <= 1'b1;
          end
        end
        HALF0, HALF1: begin
          if (rst_req) begin
            flash.flash_address <= start_addr;
            pending             <= 1'b0;
            restart_pending     <= 1'b0;
          end else if (!play) begin
            pending <= 1'b0;
          end else if (emit) begin
            pending <= pending & tick_rise;
            if (state == HALF1) flash.flash_address <= adv_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Bench: table of playback ticks plus hand sequences for pending, pause, restart and reset.
module tb_flash_sample_sequencer;

  localparam int AW = 23;
  localparam logic [AW-1:0] S_ADDR = 23'd0;
  localparam logic [AW-1:0] E_ADDR = 23'd7;

  typedef struct {
    logic          rev;
    logic [AW-1:0] addr;
    logic [15:0]   exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        play = 1'b0;
  logic        reverse = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        overrun;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  int ws_cfg = 3;
  int lat_cfg = 2;
  int stray_req = 0;
  int stray_done = 0;
  int fetch_cnt = 0;
  logic [AW-1:0] last_fetch = '0;

  int ws_left, lat_left, hold;
  bit in_read;
  logic [AW-1:0] start_a, lat_a;

  vec_t vecs[25];
  int nv;
  int vcount;

  flash_sample_sequencer_if #(.ADDR_W(AW)) flash ();

  flash_sample_sequencer #(
    .ADDR_W(AW), .START_ADDR(S_ADDR), .END_ADDR(E_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .play(play),
    .reverse(reverse), .restart(restart), .flash(flash),
    .audio_data(audio_data), .audio_valid(audio_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    if (a == 0) return 32'hBBBB_AAAA;
    if (a == 1) return 32'hDDDD_CCCC;
    return {16'h5000 | {4'h0, a[11:0]}, 16'hA000 | {4'h0, a[11:0]}};
  endfunction

  function automatic logic [15:0] lo_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = word_of(a);
    return w[15:0];
  endfunction

  function automatic logic [15:0] hi_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = word_of(a);
    return w[31:16];
  endfunction

  // Flash slave model: ws_cfg stall cycles, then data lat_cfg cycles after acceptance.
  initial begin
    flash.flash_waitrequest   = 1'b1;
    flash.flash_readdatavalid = 1'b0;
    flash.flash_readdata      = 32'h0;
    in_read = 0; ws_left = 0; lat_left = 0; hold = 0;
    forever begin
      @(negedge clk);
      flash.flash_readdatavalid = 1'b0;
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        flash.flash_readdatavalid = 1'b1;
        flash.flash_readdata      = 32'hFFFF_FFFF;
      end
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          flash.flash_readdatavalid = 1'b1;
          flash.flash_readdata      = word_of(lat_a);
        end
      end
      if (flash.flash_read) begin
        if (!in_read) begin
          in_read = 1; ws_left = ws_cfg; hold = 0; start_a = flash.flash_address;
        end
        hold++;
        if (ws_left > 0) begin
          ws_left--;
          flash.flash_waitrequest = 1'b1;
        end else begin
          flash.flash_waitrequest = 1'b0;
          in_read = 0;
          chk("addr_stable", 32'(flash.flash_address), 32'(start_a));
          chk("read_hold", 32'(hold), 32'(ws_cfg + 1));
          lat_a      = flash.flash_address;
          lat_left   = lat_cfg;
          last_fetch = flash.flash_address;
          fetch_cnt++;
        end
      end else begin
        in_read = 0;
        flash.flash_waitrequest = 1'b1;
      end
    end
  end

  // Scoreboard: every strobe must match the oldest expected sample.
  always @(negedge clk) begin
    if (audio_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual data=%h required no strobe", audio_data);
      end else begin
        chk("audio_data", 32'(audio_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge with sample_tick low; DUT must be parked in a HALF state.
  task automatic tick_expect(input logic [15:0] exp, input int gap);
    exp_q.push_back(exp);
    sample_tick = 1'b1;
    @(negedge clk); chk("tick_latency", 32'(audio_valid), 32'd1);
    @(negedge clk); chk("valid_one_cycle", 32'(audio_valid), 32'd0);
    @(negedge clk); sample_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n;
    n = 0;
    while (!audio_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(audio_valid), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_flash_read", 32'(flash.flash_read), 32'd0);
    chk("rst_flash_address", 32'(flash.flash_address), 32'(S_ADDR));
    chk("rst_audio_data", 32'(audio_data), 32'd0);
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Forward through the region, wrap to 0, reverse wrap to END, then forward again.
    nv = 0;
    for (int a = 0; a < 8; a++) begin
      vecs[nv] = '{1'b0, AW'(a), lo_of(AW'(a))}; nv++;
      vecs[nv] = '{1'b0, AW'(a), hi_of(AW'(a))}; nv++;
    end
    vecs[nv] = '{1'b1, AW'(0), hi_of(AW'(0))}; nv++;
    vecs[nv] = '{1'b1, AW'(0), lo_of(AW'(0))}; nv++;
    vecs[nv] = '{1'b1, AW'(7), hi_of(AW'(7))}; nv++;
    vecs[nv] = '{1'b1, AW'(7), lo_of(AW'(7))}; nv++;
    vecs[nv] = '{1'b1, AW'(6), hi_of(AW'(6))}; nv++;
    vecs[nv] = '{1'b1, AW'(6), lo_of(AW'(6))}; nv++;
    vecs[nv] = '{1'b0, AW'(5), lo_of(AW'(5))}; nv++;
    vecs[nv] = '{1'b0, AW'(5), hi_of(AW'(5))}; nv++;
    vecs[nv] = '{1'b0, AW'(6), lo_of(AW'(6))}; nv++;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;
    play  = 1'b1;
    repeat (12) @(negedge clk);

    for (int i = 0; i < nv; i++) begin
      reverse = vecs[i].rev;
      chk("fetch_addr", 32'(last_fetch), 32'(vecs[i].addr));
      tick_expect(vecs[i].exp, 6);
    end

    // One tick during a slow read: pended and emitted on HALF0 entry.
    ws_cfg = 0; lat_cfg = 5;
    tick_expect(hi_of(AW'(6)), 0);
    exp_q.push_back(lo_of(AW'(7)));
    pulse();
    wait_valid("pended_emit", 20);
    chk("overrun_single", 32'(overrun), 32'd0);

    // Two ticks during one read: the second is lost.
    lat_cfg = 8;
    tick_expect(hi_of(AW'(7)), 0);
    exp_q.push_back(lo_of(AW'(0)));
    pulse();
    pulse();
    wait_valid("pended_emit_2", 20);
    chk("wrap_fetch_addr", 32'(last_fetch), 32'(S_ADDR));
    chk("overrun_set", 32'(overrun), 32'd1);

    // Pause for ten ticks, then resume on the other half of the same word.
    ws_cfg = 3; lat_cfg = 2;
    play = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      pulse();
      vcount += int'(audio_valid);
      @(negedge clk);
      vcount += int'(audio_valid);
    end
    chk("pause_no_valid", 32'(vcount), 32'd0);
    chk("pause_data_held", 32'(audio_data), 32'hAAAA);
    play = 1'b1;
    tick_expect(hi_of(AW'(0)), 6);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    for (int a = 1; a < 5; a++) begin
      tick_expect(lo_of(AW'(a)), 6);
      tick_expect(hi_of(AW'(a)), 6);
    end
    tick_expect(lo_of(AW'(5)), 6);
    chk("fetch_addr_5", 32'(last_fetch), 32'd5);

    // Restart together with a tick in HALF1: no sample, refetch from START.
    sample_tick = 1'b1;
    restart     = 1'b1;
    @(negedge clk);
    restart     = 1'b0;
    sample_tick = 1'b0;
    chk("restart_no_emit", 32'(audio_valid), 32'd0);
    chk("restart_addr", 32'(flash.flash_address), 32'(S_ADDR));
    chk("restart_read", 32'(flash.flash_read), 32'd1);
    repeat (10) @(negedge clk);
    chk("restart_fetch_addr", 32'(last_fetch), 32'(S_ADDR));
    tick_expect(lo_of(AW'(0)), 6);

    // Reset while flash_read is stalled.
    tick_expect(hi_of(AW'(0)), 0);
    chk("read_before_reset", 32'(flash.flash_read), 32'd1);
    reset = 1'b1;
    play  = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray_req++;
    repeat (4) @(negedge clk);
    chk("stray_ignored_read", 32'(flash.flash_read), 32'd0);
    chk("stray_ignored_data", 32'(audio_data), 32'd0);
    play = 1'b1;
    repeat (12) @(negedge clk);
    tick_expect(lo_of(AW'(0)), 6);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
